// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: shared widths, coefficients and types for the YCbCr to RGB pipeline
package ycbcr_pkg;
    localparam int IW       = 19;
    localparam int PIPE_LAT = 4;
    typedef logic signed [IW-1:0] wide_t;
    typedef struct packed {
        wide_t r;
        wide_t g;
        wide_t b;
    } rgb_sum_t;
    localparam wide_t      COEF_CR_R  = wide_t'(359);
    localparam wide_t      COEF_CB_G  = wide_t'(88);
    localparam wide_t      COEF_CR_G  = wide_t'(183);
    localparam wide_t      COEF_CB_B  = wide_t'(454);
    localparam wide_t      ROUND      = wide_t'(128);
    localparam logic [7:0] CHROMA_OFS = 8'd128;
endpackage

// File: rtl/ycbcr_to_rgb_clamp.sv
// pixel_clamp: descale a signed fixed-point sum and saturate it to an 8-bit pixel
module pixel_clamp
    import ycbcr_pkg::*;
#(
    parameter int COEF_FRAC = 8
) (
    input  wide_t      sum,
    output logic [7:0] pix
);
    wide_t sh;
    assign sh  = sum >>> COEF_FRAC;
    assign pix = sh[IW-1] ? 8'd0 : (sh > wide_t'(255)) ? 8'd255 : sh[7:0];
endmodule

// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb: 4-stage full-range BT.601 YCbCr to RGB converter with aligned sync
module ycbcr_to_rgb
    import ycbcr_pkg::*;
#(
    parameter int COEF_FRAC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_img_vsync,
    input  logic       per_img_href,
    input  logic [7:0] per_img_Y,
    input  logic [7:0] per_img_Cb,
    input  logic [7:0] per_img_Cr,
    output logic       post_img_vsync,
    output logic       post_img_href,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);
    logic signed [8:0]   y1, cb1, cr1;
    wide_t               y2, cr_r2, cb_g2, cr_g2, cb_b2;
    rgb_sum_t            s3;
    logic [7:0]          r4, g4, b4, r_c, g_c, b_c;
    logic [PIPE_LAT-1:0] vs_sr, hs_sr;

    pixel_clamp #(.COEF_FRAC(COEF_FRAC)) u_clamp_r (.sum(s3.r), .pix(r_c));
    pixel_clamp #(.COEF_FRAC(COEF_FRAC)) u_clamp_g (.sum(s3.g), .pix(g_c));
    pixel_clamp #(.COEF_FRAC(COEF_FRAC)) u_clamp_b (.sum(s3.b), .pix(b_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            y1    <= '0;
            cb1   <= '0;
            cr1   <= '0;
            y2    <= '0;
            cr_r2 <= '0;
            cb_g2 <= '0;
            cr_g2 <= '0;
            cb_b2 <= '0;
            s3    <= '0;
            r4    <= '0;
            g4    <= '0;
            b4    <= '0;
            vs_sr <= '0;
            hs_sr <= '0;
        end else begin
            y1    <= {1'b0, per_img_Y};
            cb1   <= $signed({1'b0, per_img_Cb} - {1'b0, CHROMA_OFS});
            cr1   <= $signed({1'b0, per_img_Cr} - {1'b0, CHROMA_OFS});
            y2    <= wide_t'(y1) <<< COEF_FRAC;
            cr_r2 <= wide_t'(cr1) * COEF_CR_R;
            cb_g2 <= wide_t'(cb1) * COEF_CB_G;
            cr_g2 <= wide_t'(cr1) * COEF_CR_G;
            cb_b2 <= wide_t'(cb1) * COEF_CB_B;
            s3.r  <= y2 + cr_r2 + ROUND;
            s3.g  <= y2 - cb_g2 - cr_g2 + ROUND;
            s3.b  <= y2 + cb_b2 + ROUND;
            r4    <= r_c;
            g4    <= g_c;
            b4    <= b_c;
            vs_sr <= {vs_sr[PIPE_LAT-2:0], per_img_vsync};
            hs_sr <= {hs_sr[PIPE_LAT-2:0], per_img_href};
        end
    end

    assign post_img_vsync = vs_sr[PIPE_LAT-1];
    assign post_img_href  = hs_sr[PIPE_LAT-1];
    assign post_img_red   = post_img_href ? r4 : 8'd0;
    assign post_img_green = post_img_href ? g4 : 8'd0;
    assign post_img_blue  = post_img_href ? b4 : 8'd0;
endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// tb_ycbcr_to_rgb: table-driven and streaming self-check of the YCbCr to RGB pipeline
module tb_ycbcr_to_rgb;
    typedef struct {
        logic [7:0] y, cb, cr, r, g, b;
    } vec_t;
    typedef struct packed {
        logic       v, h;
        logic [7:0] r, g, b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       per_img_vsync = 1'b0, per_img_href = 1'b0;
    logic [7:0] per_img_Y = '0, per_img_Cb = '0, per_img_Cr = '0;
    logic       post_img_vsync, post_img_href;
    logic [7:0] post_img_red, post_img_green, post_img_blue;

    exp_t pipe [4];
    logic checking = 1'b0;
    int   n_vec = 0, n_err = 0, hs_cnt = 0, cyc = 0;
    vec_t tab [8];

    ycbcr_to_rgb #(.COEF_FRAC(8)) dut (
        .clk(clk), .rst(rst),
        .per_img_vsync(per_img_vsync), .per_img_href(per_img_href),
        .per_img_Y(per_img_Y), .per_img_Cb(per_img_Cb), .per_img_Cr(per_img_Cr),
        .post_img_vsync(post_img_vsync), .post_img_href(post_img_href),
        .post_img_red(post_img_red), .post_img_green(post_img_green), .post_img_blue(post_img_blue)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] clamp(input int x);
        return x < 0 ? 8'd0 : x > 255 ? 8'd255 : x[7:0];
    endfunction

    function automatic exp_t model(input logic v, h, input logic [7:0] y, cb, cr);
        int cbp, crp;
        exp_t e;
        cbp = int'(cb) - 128;
        crp = int'(cr) - 128;
        e.v = v;
        e.h = h;
        e.r = h ? clamp((int'(y) * 256 + 359 * crp + 128) >>> 8) : 8'd0;
        e.g = h ? clamp((int'(y) * 256 - 88 * cbp - 183 * crp + 128) >>> 8) : 8'd0;
        e.b = h ? clamp((int'(y) * 256 + 454 * cbp + 128) >>> 8) : 8'd0;
        return e;
    endfunction

    task automatic step(input logic r, v, h, input logic [7:0] y, cb, cr, input exp_t e);
        exp_t got;
        @(negedge clk);
        cyc++;
        got = {post_img_vsync, post_img_href, post_img_red, post_img_green, post_img_blue};
        if (checking) begin
            n_vec++;
            if (got !== pipe[3]) begin
                n_err++;
                $display("FAIL cycle %0d pixel: got vs=%b hs=%b rgb=%0d,%0d,%0d expected vs=%b hs=%b rgb=%0d,%0d,%0d",
                         cyc, got.v, got.h, got.r, got.g, got.b,
                         pipe[3].v, pipe[3].h, pipe[3].r, pipe[3].g, pipe[3].b);
            end
        end
        if (post_img_href === 1'b1) hs_cnt++;
        for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = e;
        rst = r;
        per_img_vsync = v;
        per_img_href = h;
        per_img_Y = y;
        per_img_Cb = cb;
        per_img_Cr = cr;
        if (r) begin
            for (int i = 0; i < 4; i++) pipe[i] = '0;
            checking = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, '0);
    endtask

    task automatic tvec(input logic v, input vec_t t);
        step(1'b0, v, 1'b1, t.y, t.cb, t.cr, exp_t'({v, 1'b1, t.r, t.g, t.b}));
    endtask

    initial begin
        tab[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
        tab[1] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
        tab[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0};
        tab[3] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        tab[4] = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        tab[5] = '{8'd100, 8'd128, 8'd200, 8'd201, 8'd49,  8'd100};
        tab[6] = '{8'd50,  8'd200, 8'd128, 8'd50,  8'd25,  8'd178};
        tab[7] = '{8'd200, 8'd50,  8'd90,  8'd147, 8'd254, 8'd62};
        for (int i = 0; i < 4; i++) pipe[i] = '0;

        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, '0);
        idle(6);

        for (int i = 0; i < 8; i++) tvec(1'b0, tab[i]);
        idle(5);

        for (int i = 0; i < 8; i++) begin
            tvec(1'b0, tab[i]);
            idle(1);
        end
        idle(4);

        step(1'b0, 1'b0, 1'b0, 8'd200, 8'd50, 8'd90, '0);
        step(1'b0, 1'b1, 1'b0, 8'd200, 8'd50, 8'd90, exp_t'({1'b1, 1'b0, 24'd0}));
        step(1'b0, 1'b0, 1'b0, 8'd200, 8'd50, 8'd90, '0);
        idle(5);

        hs_cnt = 0;
        for (int i = 0; i < 10; i++) tvec(i == 0, tab[i % 8]);
        idle(5);
        n_vec++;
        if (hs_cnt != 10) begin
            n_err++;
            $display("FAIL burst_href_len: got %0d cycles expected 10", hs_cnt);
        end

        for (int i = 0; i < 3; i++) tvec(1'b0, tab[i]);
        step(1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, '0);
        for (int i = 3; i < 8; i++) tvec(1'b0, tab[i]);
        idle(5);

        for (int i = 0; i < 10000; i++) begin
            logic       v, h;
            logic [7:0] y, cb, cr;
            v  = ($urandom_range(0, 99) == 0);
            h  = ($urandom_range(0, 7) != 0);
            y  = 8'($urandom);
            cb = 8'($urandom);
            cr = 8'($urandom);
            step(1'b0, v, h, y, cb, cr, model(v, h, y, cb, cr));
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
